fifo_rd_stream: RTL and testbench

//  Read-side drain stage for the aFIFO. Consumes the FIFO pop/empty/data_out port and presents a

---
 rtl/tb_fifo_pkg.sv | 22 ++
 rtl/fifo_skid_buf.sv | 72 +++++++
 rtl/fifo_rd_stream.sv | 79 +++++++
 tb/tb_fifo_rd_stream.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_fifo_pkg.sv
//======================================================================
// Module  : tb_fifo_pkg
// Brief   : Shared types for the aFIFO read-side drain stage.
// Revision: 1.0  initial release
//======================================================================
`default_nettype none

package tb_fifo_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_skid_buf.sv
//======================================================================
// Module  : fifo_skid_buf
// Brief   : Two-entry register FIFO; rd_data is always the head entry.
// Revision: 1.0  initial release
//======================================================================
`default_nettype none

module fifo_skid_buf
    import tb_fifo_pkg::*;
(
    input  logic       rdclk,
    input  logic       rd_rst,
    input  logic       wr_en,
    input  data_t      wr_data,
    input  logic       rd_en,
    input  logic       clr,
    output data_t      rd_data,
    output logic [1:0] count
);

    buf_state_e r_state;
    data_t      r_head;
    data_t      r_tail;

    always_ff @(posedge rdclk) begin
        if (!rd_rst) begin
            r_state <= EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (clr) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (wr_en) begin
                        r_head  <= wr_data;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    case ({wr_en, rd_en})
                        2'b10: begin
                            r_tail  <= wr_data;
                            r_state <= TWO;
                        end
                        2'b01:   r_state <= EMPTY;
                        2'b11:   r_head  <= wr_data;
                        default: r_state <= ONE;
                    endcase
                end
                TWO: begin
                    // Head retires: tail moves up, a same-cycle write refills the tail.
                    if (rd_en) begin
                        r_head <= r_tail;
                        if (wr_en) begin
                            r_tail <= wr_data;
                        end else begin
                            r_state <= ONE;
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign rd_data = r_head;
    assign count   = r_state;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
//======================================================================
// Module  : fifo_rd_stream
// Brief   : aFIFO read drain into a valid/ready stream with word and
//           flush-drop counters.
// Revision: 1.0  initial release
//======================================================================
`default_nettype none

module fifo_rd_stream
    import tb_fifo_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             rdclk,
    input  logic             rd_rst,
    input  logic             en,
    input  logic             flush,
    input  logic             empty,
    output logic             pop,
    input  data_t            data_out,
    output data_t            m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    logic             r_inflight;
    logic [1:0]       w_stored;
    logic [1:0]       w_cnt;
    logic             w_xfer;
    logic             w_capture;
    logic [CNT_W-1:0] w_drop;

    assign m_valid   = (w_stored != 2'd0);
    assign w_xfer    = m_valid & m_ready;
    assign w_cnt     = w_stored + {1'b0, r_inflight};
    // A pop may only go out if its word is guaranteed a slot when it lands.
    assign pop       = rd_rst & en & ~empty & ~flush & ((w_cnt < 2'd2) | w_xfer);
    assign w_capture = r_inflight & ~flush;
    assign w_drop    = CNT_W'(w_stored - {1'b0, w_xfer}) + CNT_W'(r_inflight);
    assign busy      = m_valid | r_inflight;

    fifo_skid_buf u_skid (
        .rdclk   (rdclk),
        .rd_rst  (rd_rst),
        .wr_en   (w_capture),
        .wr_data (data_out),
        .rd_en   (w_xfer),
        .clr     (flush),
        .rd_data (m_data),
        .count   (w_stored)
    );

    always_ff @(posedge rdclk) begin
        if (!rd_rst) begin
            r_inflight <= 1'b0;
            word_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            r_inflight <= pop;
            word_cnt   <= word_cnt + CNT_W'(w_xfer);
            if (flush) begin
                drop_cnt <= drop_cnt + w_drop;
            end
        end
    end

    a_no_pop_empty: assert property (@(posedge rdclk) disable iff (!rd_rst)
        !(pop && empty));
    a_no_overflow: assert property (@(posedge rdclk) disable iff (!rd_rst)
        !(w_capture && (w_stored == 2'd2) && !w_xfer));
    a_credit: assert property (@(posedge rdclk) disable iff (!rd_rst)
        w_cnt <= 2'd2);

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
//======================================================================
// Module  : tb_fifo_rd_stream
// Brief   : Directed self-checking bench for fifo_rd_stream.
// Revision: 1.0  initial release
//======================================================================
`default_nettype none

module tb_fifo_rd_stream;
    import tb_fifo_pkg::*;

    localparam int CNT_W = 4;

    logic             rdclk;
    logic             rd_rst;
    logic             en;
    logic             flush;
    logic             empty;
    logic             pop;
    data_t            data_out;
    data_t            m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             busy;

    int    errors = 0;
    int    checks = 0;
    int    npop;
    data_t q[$];
    data_t got[$];

    fifo_rd_stream #(.CNT_W(CNT_W)) dut (
        .rdclk    (rdclk),
        .rd_rst   (rd_rst),
        .en       (en),
        .flush    (flush),
        .empty    (empty),
        .pop      (pop),
        .data_out (data_out),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .word_cnt (word_cnt),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    initial rdclk = 1'b0;
    always #5 rdclk = ~rdclk;

    // aFIFO read port: registered data one cycle after a pop.
    always @(posedge rdclk) begin
        logic p;
        p = pop;
        #1;
        if (p && q.size() > 0) begin
            data_out = q.pop_front();
            empty    = (q.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drv();
        @(posedge rdclk);
        #2;
    endtask

    task automatic push(input data_t first, input int n);
        for (int k = 0; k < n; k++) q.push_back(data_t'(first + k));
        empty = 1'b0;
    endtask

    task automatic do_reset();
        rd_rst  = 1'b0;
        en      = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        q.delete();
        empty   = 1'b1;
        repeat (3) drv();
        rd_rst  = 1'b1;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge rdclk);
            if (pop) npop++;
            if (m_valid && m_ready) got.push_back(m_data);
            drv();
        end
    endtask

    initial begin
        rd_rst   = 1'b0;
        en       = 1'b1;
        flush    = 1'b0;
        m_ready  = 1'b1;
        data_out = '0;
        q.push_back(8'h99);
        empty    = 1'b0;

        // Reset held with data available
        drv();
        for (int i = 0; i < 3; i++) begin
            @(negedge rdclk);
            chk("rst_pop", pop, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_word_cnt", word_cnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_m_data", m_data, 0);
            drv();
        end

        // Full-rate stream of 8 words
        do_reset();
        push(8'h01, 8);
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge rdclk);
            chk("stream_pop", pop, (i < 8) ? 1 : 0);
            chk("stream_valid", m_valid, (i >= 2 && i <= 9) ? 1 : 0);
            if (i >= 2 && i <= 9) chk("stream_data", m_data, i - 1);
            drv();
        end
        @(negedge rdclk);
        chk("stream_word_cnt", word_cnt, 8);
        chk("stream_busy", busy, 0);
        drv();

        // Backpressure: only two pops, head held stable
        do_reset();
        push(8'h01, 4);
        en = 1'b1;
        m_ready = 1'b0;
        npop = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge rdclk);
            if (pop) npop++;
            if (i >= 2) begin
                chk("bp_valid", m_valid, 1);
                chk("bp_hold_data", m_data, 8'h01);
            end
            drv();
        end
        chk("bp_pop_count", npop, 2);
        m_ready = 1'b1;
        got.delete();
        collect(10);
        chk("bp_delivered", got.size(), 4);
        for (int k = 0; k < 4; k++) if (k < got.size()) chk("bp_order", got[k], k + 1);
        chk("bp_word_cnt", word_cnt, 4);

        // Single word then empty
        do_reset();
        push(8'h01, 1);
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge rdclk);
            chk("edge_pop", pop, (i == 0) ? 1 : 0);
            chk("edge_valid", m_valid, (i == 2) ? 1 : 0);
            if (i == 2) chk("edge_data", m_data, 8'h01);
            drv();
        end

        // Flush: stored=1 + inflight=1, then inflight only
        do_reset();
        push(8'h11, 4);
        en = 1'b1;
        m_ready = 1'b0;
        @(negedge rdclk); chk("fl_pop_c0", pop, 1); drv();
        @(negedge rdclk); chk("fl_pop_c1", pop, 1); drv();
        flush = 1'b1;
        @(negedge rdclk);
        chk("fl_pop_in_flush", pop, 0);
        chk("fl_valid_pre", m_valid, 1);
        drv();
        flush = 1'b0;
        @(negedge rdclk);
        chk("fl_valid_post", m_valid, 0);
        chk("fl_drop_a", drop_cnt, 2);
        chk("fl_pop_resume", pop, 1);
        drv();
        flush = 1'b1;
        @(negedge rdclk);
        chk("fl_pop_in_flush2", pop, 0);
        drv();
        flush = 1'b0;
        @(negedge rdclk);
        chk("fl_drop_b", drop_cnt, 3);
        chk("fl_valid_post2", m_valid, 0);
        chk("fl_pop_resume2", pop, 1);
        drv();
        m_ready = 1'b1;
        got.delete();
        collect(6);
        chk("fl_delivered", got.size(), 1);
        if (got.size() > 0) chk("fl_late_ignored", got[0], 8'h14);
        chk("fl_word_cnt", word_cnt, 1);

        // Counter wrap with 17 transfers, then en dropped mid-stream
        do_reset();
        push(8'h40, 17);
        en = 1'b1;
        m_ready = 1'b1;
        got.delete();
        collect(30);
        chk("wrap_transfers", got.size(), 17);
        chk("wrap_word_cnt", word_cnt, 1);
        got.delete();
        push(8'h21, 6);
        @(negedge rdclk); chk("en_pop_c0", pop, 1); drv();
        @(negedge rdclk); chk("en_pop_c1", pop, 1); drv();
        en = 1'b0;
        npop = 0;
        collect(8);
        chk("en_no_pop", npop, 0);
        chk("en_drained", got.size(), 2);
        if (got.size() > 1) begin
            chk("en_drain0", got[0], 8'h21);
            chk("en_drain1", got[1], 8'h22);
        end
        chk("en_word_cnt", word_cnt, 3);
        chk("en_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
